player_action_ctrl: RTL

//  Frame-paced command sequencer between raw key inputs and one Player instance.

---
 rtl/player_action_ctrl_if.sv | 29 ++
 rtl/player_action_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/player_action_ctrl_if.sv
// Bundle between the key/frame source and the player action sequencer.
// The master drives keys, frame pacing and Player feedback; the slave returns commands and status.
interface player_action_ctrl_if;
    logic       frame_tick;
    logic       freeze;
    logic       key_right;
    logic       key_left;
    logic       key_jump;
    logic       key_squat;
    logic       key_defend;
    logic       player_isJ;
    logic       right;
    logic       left;
    logic       jump;
    logic       squat;
    logic       defend;
    logic [7:0] stamina;
    logic [1:0] state;

    modport master (
        output frame_tick, freeze, key_right, key_left, key_jump, key_squat, key_defend, player_isJ,
        input  right, left, jump, squat, defend, stamina, state
    );

    modport slave (
        input  frame_tick, freeze, key_right, key_left, key_jump, key_squat, key_defend, player_isJ,
        output right, left, jump, squat, defend, stamina, state
    );
endinterface

// File: rtl/player_action_ctrl.sv
// Frame-paced key-to-command sequencer with jump cooldown and a defend-stamina FSM.
// Macro PLAYER_CTRL_STAMINA_EN enables stamina drain/recover and the EXHAUST state.
module player_action_ctrl #(
    parameter int unsigned JUMP_COOLDOWN   = 24,
    parameter int unsigned STAMINA_MAX     = 60,
    parameter int unsigned STAMINA_DRAIN   = 2,
    parameter int unsigned STAMINA_RECOVER = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    player_action_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_GUARD   = 2'd1,
        S_EXHAUST = 2'd2,
        S_FROZEN  = 2'd3
    } state_t;

    localparam logic [7:0] ST_MAX  = 8'(STAMINA_MAX);
    localparam logic [7:0] CD_INIT = 8'(JUMP_COOLDOWN);

    state_t     state_q, state_d;
    logic [4:0] key_meta_q, key_sync_q;
    logic       jump_prev_q;
    logic       jump_pend_q, jump_pend_d;
    logic [7:0] cooldown_q, cooldown_d;
    logic [7:0] stamina_q, stamina_d;
    logic       right_q, right_d;
    logic       left_q, left_d;
    logic       jump_q, jump_d;
    logic       squat_q, squat_d;
    logic       defend_q, defend_d;

    logic k_right, k_left, k_jump, k_squat, k_defend;
    logic jump_edge, pend_eff, tick, halted;
    logic [7:0] stam_up, stam_dn;

    assign k_right  = key_sync_q[0];
    assign k_left   = key_sync_q[1];
    assign k_jump   = key_sync_q[2];
    assign k_squat  = key_sync_q[3];
    assign k_defend = key_sync_q[4];

    // A jump edge coinciding with the tick takes part in that tick's decision.
    assign jump_edge = k_jump & ~jump_prev_q;
    assign pend_eff  = jump_pend_q | jump_edge;
    assign tick      = bus.frame_tick;
    assign halted    = bus.freeze | (state_q == S_FROZEN);

`ifdef PLAYER_CTRL_STAMINA_EN
    logic [8:0] stam_up9, stam_dn9;
    assign stam_up9 = {1'b0, stamina_q} + 9'(STAMINA_RECOVER);
    assign stam_dn9 = {1'b0, stamina_q} - 9'(STAMINA_DRAIN);
    assign stam_up  = (stam_up9 >= 9'(STAMINA_MAX)) ? ST_MAX : stam_up9[7:0];
    // Bit 8 set means the subtraction went below zero.
    assign stam_dn  = stam_dn9[8] ? 8'd0 : stam_dn9[7:0];
`else
    assign stam_up  = stamina_q;
    assign stam_dn  = stamina_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FREE;
            key_meta_q  <= '0;
            key_sync_q  <= '0;
            jump_prev_q <= 1'b0;
            jump_pend_q <= 1'b0;
            cooldown_q  <= '0;
            stamina_q   <= ST_MAX;
            right_q     <= 1'b0;
            left_q      <= 1'b0;
            jump_q      <= 1'b0;
            squat_q     <= 1'b0;
            defend_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_meta_q  <= {bus.key_defend, bus.key_squat, bus.key_jump, bus.key_left, bus.key_right};
            key_sync_q  <= key_meta_q;
            jump_prev_q <= k_jump;
            jump_pend_q <= jump_pend_d;
            cooldown_q  <= cooldown_d;
            stamina_q   <= stamina_d;
            right_q     <= right_d;
            left_q      <= left_d;
            jump_q      <= jump_d;
            squat_q     <= squat_d;
            defend_q    <= defend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.freeze) begin
            state_d = S_FROZEN;
        end else if (state_q == S_FROZEN) begin
            state_d = S_FREE;
        end else if (tick) begin
            case (state_q)
                S_FREE: begin
                    if (k_defend && (stamina_q != 8'd0)) state_d = S_GUARD;
                end
                S_GUARD: begin
                    if (!k_defend) begin
                        state_d = S_FREE;
                    end
`ifdef PLAYER_CTRL_STAMINA_EN
                    else if (stam_dn == 8'd0) begin
                        state_d = S_EXHAUST;
                    end
`endif
                end
                S_EXHAUST: begin
                    if (stam_up == ST_MAX) state_d = S_FREE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        right_d     = 1'b0;
        left_d      = 1'b0;
        jump_d      = 1'b0;
        squat_d     = squat_q;
        defend_d    = defend_q;
        stamina_d   = stamina_q;
        cooldown_d  = cooldown_q;
        jump_pend_d = pend_eff;
        if (halted) begin
            squat_d     = 1'b0;
            defend_d    = 1'b0;
            jump_pend_d = 1'b0;
        end else if (tick) begin
            // Every tick consumes the pend: it either issues now or is dropped.
            jump_pend_d = 1'b0;
            cooldown_d  = (cooldown_q != 8'd0) ? cooldown_q - 8'd1 : 8'd0;
            case (state_q)
                S_FREE: begin
                    stamina_d = stam_up;
                    if (state_d == S_GUARD) begin
                        defend_d = 1'b1;
                        squat_d  = 1'b0;
                    end else begin
                        defend_d = 1'b0;
                        squat_d  = k_squat;
                        right_d  = k_right & ~k_left & ~k_squat;
                        left_d   = k_left & ~k_right & ~k_squat;
                        if (pend_eff && (cooldown_q == 8'd0) && !bus.player_isJ && !k_squat) begin
                            jump_d     = 1'b1;
                            cooldown_d = CD_INIT;
                        end
                    end
                end
                S_GUARD: begin
                    squat_d = 1'b0;
                    if (!k_defend) begin
                        defend_d = 1'b0;
                    end else begin
                        stamina_d = stam_dn;
                        defend_d  = (state_d == S_GUARD);
                    end
                end
                S_EXHAUST: begin
                    defend_d  = 1'b0;
                    squat_d   = k_squat;
                    right_d   = k_right & ~k_left & ~k_squat;
                    left_d    = k_left & ~k_right & ~k_squat;
                    stamina_d = stam_up;
                end
                default: begin
                    squat_d  = 1'b0;
                    defend_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.right   = right_q;
    assign bus.left    = left_q;
    assign bus.jump    = jump_q;
    assign bus.squat   = squat_q;
    assign bus.defend  = defend_q;
    assign bus.stamina = stamina_q;
    assign bus.state   = state_q;

endmodule
